// File: rtl/shift_exec_stage_pkg.sv
// shift_exec_stage_pkg: op encodings and shared constants for the shift/rotate execute stage
package shift_exec_stage_pkg;
  localparam int DATA_W = 32;
  localparam logic [4:0] CNT_MASK = 5'h1F;
  typedef enum logic [2:0] {
    OP_SHR  = 3'd0,
    OP_SHRA = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4
  } op_e;
endpackage

// File: rtl/shift_rot_core.sv
// shift_rot_core: combinational shift/rotate datapath; illegal ops pass a through
module shift_rot_core #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [4:0]        amt,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);
  import shift_exec_stage_pkg::*;
  logic [5:0] inv;
  logic [DATA_W-1:0] sra, ror, rol;
  always_comb begin
    inv = 6'(DATA_W) - {1'b0, amt};
    sra = $signed(a) >>> amt;
    // a shift by the full width yields 0, so amt=0 rotates collapse to a
    ror = (a >> amt) | (a << inv);
    rol = (a << amt) | (a >> inv);
    illegal = op > OP_ROL;
    result = op == OP_SHR  ? a >> amt :
             op == OP_SHRA ? sra :
             op == OP_SHL  ? a << amt :
             op == OP_ROR  ? ror :
             op == OP_ROL  ? rol : a;
  end
endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage shift/rotate execute (operand latch, Z register) with valid/ready
module shift_exec_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);
  import shift_exec_stage_pkg::*;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [2:0]        s1_op;
  logic [4:0]        s1_amt;
  logic [DATA_W-1:0] core_result;
  logic              core_illegal;
  logic              accept, load, handoff;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = s1_valid && (!out_valid || out_ready);
  assign handoff  = out_valid && out_ready;
  assign busy     = s1_valid || out_valid;
  shift_rot_core #(.DATA_W(DATA_W)) u_core (
    .a(s1_a),
    .amt(s1_amt),
    .op(s1_op),
    .result(core_result),
    .illegal(core_illegal)
  );
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_op     <= '0;
      s1_amt    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_op    <= op;
        s1_amt   <= CNT_MASK & 5'(b % 32'(DATA_W));
      end else if (load) begin
        s1_valid <= 1'b0;
      end
      if (load) begin
        out_valid <= 1'b1;
        result    <= core_result;
        illegal   <= core_illegal;
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
      if (handoff && op_count != '1) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: directed checks of shift/rotate results, handshake, counter and async reset
module tb_shift_exec_stage;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        illegal;
  logic        busy;
  logic [15:0] op_count;
  int checks = 0;
  int failures = 0;

  shift_exec_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic run_one(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = va; b = vb; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_shifts();
    run_one(3'd4, 32'h80000001, 32'd1);
    checks++; if (out_valid !== 1'b1 || result !== 32'h00000003) begin failures++; $display("FAIL rol1 got=%h v=%b exp=00000003", result, out_valid); end
    run_one(3'd3, 32'h00000001, 32'd1);
    checks++; if (result !== 32'h80000000) begin failures++; $display("FAIL ror1 got=%h exp=80000000", result); end
    run_one(3'd1, 32'h80000000, 32'd4);
    checks++; if (result !== 32'hF8000000) begin failures++; $display("FAIL shra4 got=%h exp=f8000000", result); end
    run_one(3'd0, 32'h80000000, 32'd4);
    checks++; if (result !== 32'h08000000) begin failures++; $display("FAIL shr4 got=%h exp=08000000", result); end
    run_one(3'd2, 32'h0000FFFF, 32'd16);
    checks++; if (result !== 32'hFFFF0000 || illegal !== 1'b0) begin failures++; $display("FAIL shl16 got=%h ill=%b exp=ffff0000 ill=0", result, illegal); end
    run_one(3'd1, 32'h80000000, 32'd31);
    checks++; if (result !== 32'hFFFFFFFF) begin failures++; $display("FAIL shra31 got=%h exp=ffffffff", result); end
    run_one(3'd4, 32'h00000001, 32'd31);
    checks++; if (result !== 32'h80000000) begin failures++; $display("FAIL rol31 got=%h exp=80000000", result); end
    run_one(3'd3, 32'h0000000F, 32'd4);
    checks++; if (result !== 32'hF0000000) begin failures++; $display("FAIL ror4 got=%h exp=f0000000", result); end
  endtask

  task automatic test_count_wrap();
    run_one(3'd4, 32'h00000001, 32'd33);
    checks++; if (result !== 32'h00000002) begin failures++; $display("FAIL rol33 got=%h exp=00000002", result); end
    run_one(3'd3, 32'h12345678, 32'd32);
    checks++; if (result !== 32'h12345678) begin failures++; $display("FAIL ror32 got=%h exp=12345678", result); end
    run_one(3'd0, 32'hCAFEF00D, 32'hFFFFFFE0);
    checks++; if (result !== 32'hCAFEF00D) begin failures++; $display("FAIL shr_hibits got=%h exp=cafef00d", result); end
    run_one(3'd6, 32'hDEADBEEF, 32'd5);
    checks++; if (result !== 32'hDEADBEEF || illegal !== 1'b1) begin failures++; $display("FAIL illegal6 got=%h ill=%b exp=deadbeef ill=1", result, illegal); end
    @(negedge clk);
    checks++; if (op_count !== 16'd12) begin failures++; $display("FAIL count_after_singles got=%0d exp=12", op_count); end
  endtask

  task automatic test_backpressure();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 32'd1; b = 32'd1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got=%b exp=1", in_ready); end
    b = 32'd2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || result !== 32'd2) begin failures++; $display("FAIL bp_full got ready=%b res=%h exp ready=0 res=00000002", in_ready, result); end
    b = 32'd3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || result !== 32'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got ready=%b res=%h v=%b exp 0/00000002/1", in_ready, result, out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_comb got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (result !== 32'd4) begin failures++; $display("FAIL bp_second got=%h exp=00000004", result); end
    @(negedge clk);
    checks++; if (result !== 32'd8 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_third got=%h v=%b exp=00000008", result, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || op_count !== 16'd3) begin failures++; $display("FAIL bp_count got v=%b cnt=%0d exp v=0 cnt=3", out_valid, op_count); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; op = 3'd2; a = 32'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || result !== (32'd1 << (i - 2))) begin failures++; $display("FAIL stream_%0d got=%h v=%b exp=%h", i - 2, result, out_valid, 32'd1 << (i - 2)); end
      end
      if (i < 10) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
      end
      in_valid = i < 10; b = i;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (op_count !== 16'd13 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_count got=%0d v=%b exp=13 v=0", op_count, out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 32'h55; b = 32'd1;
    @(negedge clk);
    b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got busy=%b ready=%b exp 1/0", busy, in_ready); end
    #2 clr = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0 || result !== 32'd0) begin failures++; $display("FAIL mid_async got v=%b busy=%b cnt=%0d res=%h exp all 0", out_valid, busy, op_count, result); end
    @(negedge clk); clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d got v=%b busy=%b exp 0/0", i, out_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_count_wrap();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
